// File: rtl/histogram_eq_lut_builder.sv
// histogram_eq_lut_builder: sweeps histogram bins into a CDF-based equalization LUT (double-buffered)
// and remaps a pixel stream through the active bank.
module histogram_eq_lut_builder #(
    parameter int PIXELS_LOG2 = 16,
    parameter int CDF_W = PIXELS_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hist_ready,
    output logic [7:0]       hist_addr_rd,
    input  logic [15:0]      hist_data_rd,
    input  logic [7:0]       in_pixel,
    input  logic             in_valid,
    output logic [7:0]       out_pixel,
    output logic             out_valid,
    output logic             lut_done,
    output logic [CDF_W-1:0] total_count,
    output logic             count_err
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, SWAP = 2'd3;
    localparam logic [CDF_W-1:0] CDF_MAX = '1;
    localparam logic [CDF_W-1:0] FULL = CDF_W'(1) << PIXELS_LOG2;
    logic [1:0] state;
    logic pending, lut_loaded, bank, sat, rd_v, wr_v;
    logic [7:0] rd_k, wr_k, map;
    logic [CDF_W-1:0] cdf;
    logic [CDF_W:0] sum;
    logic [CDF_W+7:0] scaled;
    logic [7:0] lut [0:511];
    always_comb begin
        sum = {1'b0, cdf} + (CDF_W+1)'(hist_data_rd);
        scaled = ((CDF_W+8)'(cdf) * (CDF_W+8)'(255)) >> PIXELS_LOG2;
        map = |scaled[CDF_W+7:8] ? 8'hff : scaled[7:0];
    end
    assign lut_done = state == SWAP;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pending <= 1'b0;
            lut_loaded <= 1'b0;
            bank <= 1'b0;
            hist_addr_rd <= 8'd0;
            total_count <= '0;
            count_err <= 1'b0;
            cdf <= '0;
            sat <= 1'b0;
            rd_v <= 1'b0;
            wr_v <= 1'b0;
            rd_k <= 8'd0;
            wr_k <= 8'd0;
        end else begin
            // bin data arrives one cycle after its address, CDF one cycle after that
            rd_v <= state == READ;
            rd_k <= hist_addr_rd;
            wr_v <= rd_v;
            wr_k <= rd_k;
            if (rd_v) begin
                cdf <= sum[CDF_W] ? CDF_MAX : sum[CDF_W-1:0];
                sat <= sat | sum[CDF_W];
            end
            if (hist_ready && state != IDLE) pending <= 1'b1;
            case (state)
                IDLE: begin
                    hist_addr_rd <= 8'd0;
                    cdf <= '0;
                    sat <= 1'b0;
                    if (hist_ready) state <= READ;
                end
                READ: begin
                    if (hist_addr_rd == 8'hff) state <= DRAIN;
                    else hist_addr_rd <= hist_addr_rd + 8'd1;
                end
                DRAIN: if (wr_v && wr_k == 8'hff) state <= SWAP;
                SWAP: begin
                    bank <= ~bank;
                    lut_loaded <= 1'b1;
                    total_count <= cdf;
                    count_err <= sat || cdf != FULL;
                    cdf <= '0;
                    sat <= 1'b0;
                    hist_addr_rd <= 8'd0;
                    pending <= 1'b0;
                    state <= (pending || hist_ready) ? READ : IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk) if (wr_v) lut[{~bank, wr_k}] <= map;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pixel <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_pixel <= lut_loaded ? lut[{bank, in_pixel}] : in_pixel;
        end
    end
endmodule

// File: tb/tb_histogram_eq_lut_builder.sv
// tb_histogram_eq_lut_builder: directed frames with a pixel scoreboard and LUT reference model.
module tb_histogram_eq_lut_builder;
    localparam int P = 16;
    localparam int CW = P + 1;
    logic clk = 0, rst = 1, hist_ready = 0, in_valid = 0;
    logic [7:0] hist_addr_rd, out_pixel, in_pixel = 0;
    logic [15:0] hist_data_rd;
    logic out_valid, lut_done, count_err;
    logic [CW-1:0] total_count;
    histogram_eq_lut_builder #(.PIXELS_LOG2(P), .CDF_W(CW)) dut (
        .clk(clk), .rst(rst), .hist_ready(hist_ready), .hist_addr_rd(hist_addr_rd),
        .hist_data_rd(hist_data_rd), .in_pixel(in_pixel), .in_valid(in_valid),
        .out_pixel(out_pixel), .out_valid(out_valid), .lut_done(lut_done),
        .total_count(total_count), .count_err(count_err)
    );
    always #5 clk = ~clk;
    logic [15:0] hist_mem [256];
    always @(posedge clk) hist_data_rd <= hist_mem[hist_addr_rd];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_chk = 0, n_pass = 0, n_fail = 0, done_cnt = 0, last_done = 0, t_rdy = 0, t0 = 0, t1 = 0;
    int exp_q[$];
    logic [7:0] model_lut [256];
    logic [7:0] pend_lut [256];
    bit model_loaded = 0, pend_err = 0;
    int pend_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] p, input bit v, input int e = -1);
        in_pixel = p;
        in_valid = v;
        if (v) exp_q.push_back(e >= 0 ? e : (model_loaded ? int'(model_lut[p]) : int'(p)));
        tick();
        in_valid = 0;
    endtask

    // mode 0: uniform 256/bin; 1: one count in bin 99, rest in bin 100; 2: bin 0 short by one
    task automatic fill(input int mode);
        longint c = 0, m;
        bit s = 0;
        for (int k = 0; k < 256; k++)
            hist_mem[k] = mode == 0 ? 16'd256 : mode == 2 ? (k == 0 ? 16'd255 : 16'd256)
                        : (k == 99 ? 16'd1 : k == 100 ? 16'd65535 : 16'd0);
        for (int k = 0; k < 256; k++) begin
            c += hist_mem[k];
            if (c > (longint'(1) << CW) - 1) begin
                c = (longint'(1) << CW) - 1;
                s = 1;
            end
            m = (c * 255) >>> P;
            pend_lut[k] = m > 255 ? 8'd255 : 8'(m);
        end
        pend_total = int'(c);
        pend_err = s || c != (longint'(1) << P);
    endtask

    task automatic pulse();
        hist_ready = 1;
        t_rdy = cyc;
        tick();
        hist_ready = 0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 600 && done_cnt < target; i++)
            drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        chk("done_count", done_cnt, target);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() > 0) chk("pixel", out_pixel, exp_q.pop_front());
            else chk("pixel_unexpected", out_pixel, 32'hffff_ffff);
        end
        if (lut_done) begin
            done_cnt++;
            last_done = cyc;
            model_lut = pend_lut;
            model_loaded = 1;
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_addr", hist_addr_rd, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_lut_done", lut_done, 0);
        chk("rst_total", total_count, 0);
        chk("rst_err", count_err, 0);
        rst = 0;
        tick();
        drive(0, 1, 0);
        chk("id_valid", out_valid, 1);
        drive(37, 1, 37);
        drive(255, 1, 255);
        tick();
        chk("id_valid_low", out_valid, 0);
        fill(0);
        pulse();
        t0 = t_rdy;
        wait_done(1);
        chk("uni_done_at", last_done, t0 + 259);
        chk("done_pulse", lut_done, 0);
        chk("uni_total", total_count, 65536);
        chk("uni_err", count_err, 0);
        drive(0, 1, 0);
        drive(127, 1, 127);
        drive(255, 1, 255);
        fill(1);
        pulse();
        wait_done(2);
        drive(99, 1, 0);
        drive(0, 1, 0);
        drive(100, 1, 255);
        drive(255, 1, 255);
        fill(2);
        pulse();
        wait_done(3);
        chk("err_total", total_count, 65535);
        chk("err_flag", count_err, 1);
        drive(255, 1, 254);
        fill(0);
        pulse();
        repeat (5) tick();
        chk("err_sticky", count_err, 1);
        wait_done(4);
        chk("clean_err", count_err, 0);
        chk("clean_total", total_count, 65536);
        pulse();
        t0 = t_rdy;
        repeat (10) tick();
        pulse();
        repeat (20) tick();
        pulse();
        wait_done(5);
        t1 = last_done;
        chk("dbl_first_at", t1, t0 + 259);
        chk("dbl_addr0", hist_addr_rd, 0);
        tick();
        chk("dbl_addr1", hist_addr_rd, 1);
        wait_done(6);
        chk("dbl_second_at", last_done, t1 + 259);
        repeat (300) tick();
        chk("dbl_no_third", done_cnt, 6);
        chk("dbl_idle_addr", hist_addr_rd, 0);
        fill(1);
        pulse();
        for (int i = 0; i < 300 && hist_addr_rd != 8'd130; i++) tick();
        chk("addr130", hist_addr_rd, 130);
        rst = 1;
        model_loaded = 0;
        tick();
        rst = 0;
        chk("rst_mid_addr", hist_addr_rd, 0);
        chk("rst_mid_done", lut_done, 0);
        repeat (300) tick();
        chk("rst_mid_no_done", done_cnt, 6);
        chk("rst_mid_idle", hist_addr_rd, 0);
        drive(200, 1, 200);
        drive(17, 1, 17);
        fill(0);
        pulse();
        t0 = t_rdy;
        wait_done(7);
        chk("post_rst_done_at", last_done, t0 + 259);
        chk("post_rst_total", total_count, 65536);
        drive(200, 1, 200);
        tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/histogram_eq_lut_builder.md
Name: histogram_eq_lut_builder

Overview:
Consumer side of the histogram RAM read port. When the histogram calculator signals a finished frame, this block sweeps all 256 bins through the external read port and accumulates the cumulative distribution. It converts the distribution into an 8-bit equalization LUT held in a double-buffered internal RAM. It also remaps an incoming pixel stream through the active LUT, so it sits between the histogram stage and the next filter stage.

Parameters:
PIXELS_LOG2, 16, log2 of pixels per frame; CDF normalisation is a right shift by this amount.
CDF_W, PIXELS_LOG2+1, cumulative-sum register width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
hist_ready  in  1  one-cycle pulse: histogram RAM holds a complete frame (calculator out_valid)
hist_addr_rd  out  8  read address into histogram RAM
hist_data_rd  in  16  bin count; valid the cycle after the address is presented (registered BRAM read)
in_pixel  in  8  pixel to remap
in_valid  in  1  in_pixel qualifier
out_pixel  out  8  remapped pixel
out_valid  out  1  out_pixel qualifier
lut_done  out  1  one-cycle pulse: new LUT active
total_count  out  CDF_W  final CDF of last completed sweep
count_err  out  1  sticky until next lut_done: total_count != 2**PIXELS_LOG2

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values:
  - hist_addr_rd=0, out_pixel=0, out_valid=0, lut_done=0, total_count=0, count_err=0.
  - FSM=IDLE, pending=0, lut_loaded=0, active_bank=0.
  - LUT RAM contents are not reset.
- FSM states: IDLE, READ, DRAIN, SWAP.
  - IDLE: hist_ready sampled high at cycle T -> READ at T+1. Clear cdf to 0.
  - READ: hist_addr_rd = 0..255 on cycles T+1..T+256, one per cycle. After address 255 -> DRAIN.
  - DRAIN: wait until the write of LUT entry 255 (cycle T+258) -> SWAP.
  - SWAP (cycle T+259), single cycle:
    - toggle active_bank, set lut_loaded=1;
    - lut_done=1; load total_count and count_err;
    - -> READ if pending, else IDLE; clear pending.
- Data path per bin k:
  - hist_data_rd valid at T+2+k.
  - cdf_k = cdf_(k-1) + bin, registered at T+3+k.
  - map_k = min(255, (cdf_k*255) >> PIXELS_LOG2), computed at full width (CDF_W+8 bits), no truncation before the shift.
  - map_k written to the inactive bank, address k, in cycle T+3+k.
- Cumulative sum:
  - cdf saturates at 2**CDF_W-1; it never wraps.
  - count_err is set on saturation or when final cdf != 2**PIXELS_LOG2.
- hist_ready outside IDLE sets pending (multiple pulses collapse to one). It never restarts or corrupts the current sweep.
- hist_ready coincident with SWAP is treated as pending and starts the next sweep at the following cycle.
- Pixel path, latency 1 cycle:
  - out_valid(t+1) = in_valid(t).
  - out_pixel(t+1) = in_pixel(t) if lut_loaded=0, else LUT[active_bank][in_pixel(t)].
  - Pixels presented in or before the SWAP cycle use the old bank; pixels from SWAP+1 use the new bank.
  - The pixel path never stalls; LUT reads and the sweep write use separate RAM ports/banks.
- Reset mid-sweep:
  - abandons the sweep and returns to IDLE;
  - lut_loaded=0, so output reverts to identity mapping;
  - no lut_done is issued.
- hist_addr_rd holds 255 in DRAIN/SWAP and returns to 0 in IDLE.

Test Plan:
- After reset, no sweep; in_pixel 0,37,255 with in_valid -> out_pixel 0,37,255 one cycle later, out_valid aligned.
- PIXELS_LOG2=16, every bin=256, hist_ready at T -> lut_done only at T+259. LUT[0]=0, LUT[127]=127, LUT[255]=255; total_count=65536, count_err=0.
- All 65536 pixels in bin 100 -> pixels 0..99 map to 0, 100..255 map to 255; pixel stream during the sweep still shows identity until SWAP+1.
- Bin sum 65535 (bin 0=255, others 256) -> count_err=1, total_count=65535; LUT[255]=254; a clean second frame clears count_err at its lut_done.
- hist_ready pulsed twice during READ -> exactly one extra sweep, whose READ starts the cycle after the first lut_done; two lut_done pulses total.
- rst asserted at address 130 of the first sweep -> FSM IDLE next cycle, no lut_done, out_pixel reverts to identity; a new hist_ready completes normally.
